// File: rtl/sbase_pkg.sv
// Shared types and constants for the 4-state strobe responder.
package sbase_pkg;

    localparam int NSLOT = 4;
    localparam int IW    = $clog2(NSLOT);

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ORDER    = 3'd1;
    localparam logic [2:0] ERR_MISMATCH = 3'd2;
    localparam logic [2:0] ERR_OVERRUN  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

endpackage

// File: rtl/sbase_state4_resp_if.sv
// Bundle of sequencer strobes, frame handshake and error lines.
// master: sequencer + downstream consumer side; slave: the responder.
interface sbase_state4_resp_if #(
    parameter int W = 8
) ();
    logic           STATE0, STATE1, STATE2, STATE3;
    logic           POUT_ONE0, POUT_ONE1, POUT_ONE2, POUT_ONE3;
    logic [W-1:0]   DIN;
    logic           RDY_OUT;
    logic [4*W-1:0] DOUT;
    logic           DVALID;
    logic           DACK;
    logic           ERR;
    logic [2:0]     ERR_CODE;
    logic           ERR_CLR;

    modport master (
        output STATE0, STATE1, STATE2, STATE3,
        output POUT_ONE0, POUT_ONE1, POUT_ONE2, POUT_ONE3,
        output DIN, DACK, ERR_CLR,
        input  RDY_OUT, DOUT, DVALID, ERR, ERR_CODE
    );

    modport slave (
        input  STATE0, STATE1, STATE2, STATE3,
        input  POUT_ONE0, POUT_ONE1, POUT_ONE2, POUT_ONE3,
        input  DIN, DACK, ERR_CLR,
        output RDY_OUT, DOUT, DVALID, ERR, ERR_CODE
    );
endinterface

// File: rtl/sbase_strobe_check.sv
// Combinational classifier for one cycle of strobes: which slot is being
// strobed, whether it is a clean strobe, and whether it is the expected one.
module sbase_strobe_check
    import sbase_pkg::*;
(
    input  logic [NSLOT-1:0] state_i,
    input  logic [NSLOT-1:0] pout_i,
    input  idx_t             exp_i,
    output logic             valid_o,
    output idx_t             k_o,
    output logic             in_order_o,
    output logic             mismatch_o
);
    logic multi;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi = |(pout_i & (pout_i - 1'b1));

    // Encode the strobed slot; only meaningful when exactly one strobe is high.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        k_o = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (pout_i[i]) k_o = idx_t'(i);
        end
    end

    assign mismatch_o = multi | (|(pout_i & ~state_i));
    assign valid_o    = (|pout_i) & ~mismatch_o;
    assign in_order_o = valid_o & (k_o == exp_i);
endmodule

// File: rtl/sbase_state4_resp.sv
// Receive-side responder: collects one DIN word per state strobe into a
// 4-slot frame, hands it downstream with DVALID/DACK and throttles the
// sequencer through RDY_OUT. Optional collect timeout: SBASE_RESP_TIMEOUT_EN.
module sbase_state4_resp
    import sbase_pkg::*;
#(
    parameter int W = 8
`ifdef SBASE_RESP_TIMEOUT_EN
    , parameter int TMO_CYC = 255
`endif
) (
    input logic           CLK,
    input logic           R,
    sbase_state4_resp_if.slave bus
);
    state_e                  state_q, state_d;
    idx_t                    exp_q, exp_d;
    logic [NSLOT-1:0][W-1:0] frame_q, frame_d;
    logic                    rdy_q, rdy_d;
    logic                    dvalid_q, dvalid_d;
    logic                    err_q, err_d;
    logic [2:0]              code_q, code_d;

    logic [NSLOT-1:0] state_v, pout_v;
    logic             s_valid, s_in_order, s_mismatch;
    idx_t             s_k;
    logic             any_strobe;
    logic             tmo;
    logic             new_err;
    logic [2:0]       new_code;

    assign state_v    = {bus.STATE3, bus.STATE2, bus.STATE1, bus.STATE0};
    assign pout_v     = {bus.POUT_ONE3, bus.POUT_ONE2, bus.POUT_ONE1, bus.POUT_ONE0};
    assign any_strobe = |pout_v;

    sbase_strobe_check u_chk (
        .state_i    (state_v),
        .pout_i     (pout_v),
        .exp_i      (exp_q),
        .valid_o    (s_valid),
        .k_o        (s_k),
        .in_order_o (s_in_order),
        .mismatch_o (s_mismatch)
    );

`ifdef SBASE_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Idle-cycle counter while collecting; saturates at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != COLLECT || s_valid) cnt_d = '0;
        else if (cnt_q != CW'(TMO_CYC))   cnt_d = cnt_q + 1'b1;
    end

    // A strobe coinciding with the terminal count takes precedence.
    assign tmo = (state_q == COLLECT) && !any_strobe && (cnt_q == CW'(TMO_CYC));

    // Timeout counter register.
    always_ff @(posedge CLK or posedge R) begin
        if (R) cnt_q <= '0;
        else   cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    // Next-state, frame capture and error classification.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        frame_d  = frame_q;
        new_err  = 1'b0;
        new_code = ERR_NONE;
        case (state_q)
            IDLE, COLLECT: begin
                if (s_mismatch) begin
                    new_err  = 1'b1;
                    new_code = ERR_MISMATCH;
                    state_d  = IDLE;
                    exp_d    = '0;
                end else if (s_in_order) begin
                    frame_d[s_k] = bus.DIN;
                    if (s_k == idx_t'(NSLOT - 1)) begin
                        state_d = HOLD;
                        exp_d   = '0;
                    end else begin
                        state_d = COLLECT;
                        exp_d   = s_k + 1'b1;
                    end
                end else if (s_valid) begin
                    new_err  = 1'b1;
                    new_code = ERR_ORDER;
                    state_d  = IDLE;
                    exp_d    = '0;
                end else if (tmo) begin
                    new_err  = 1'b1;
                    new_code = ERR_TIMEOUT;
                    state_d  = IDLE;
                    exp_d    = '0;
                end
            end
            HOLD: begin
                // The completed frame is never disturbed by strobes here; a
                // malformed one is still reported as a mismatch.
                if (s_mismatch) begin
                    new_err  = 1'b1;
                    new_code = ERR_MISMATCH;
                end else if (any_strobe) begin
                    new_err  = 1'b1;
                    new_code = ERR_OVERRUN;
                end
                if (bus.DACK) begin
                    state_d = IDLE;
                    exp_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                exp_d   = '0;
            end
        endcase
    end

    // Sticky error: first code since the last clear wins; a new error beats ERR_CLR.
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (bus.ERR_CLR) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
        end
        if (new_err) begin
            err_d = 1'b1;
            if (!err_q || bus.ERR_CLR) code_d = new_code;
        end
    end

    // Handshake outputs follow the next state so they are registered with it.
    assign rdy_d    = (state_d != HOLD);
    assign dvalid_d = (state_d == HOLD);

    // State, frame and output registers.
    always_ff @(posedge CLK or posedge R) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (R) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            // NOTE: the frame store is reset because DOUT must read zero during reset.
            frame_q  <= '0;
            rdy_q    <= 1'b0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            frame_q  <= frame_d;
            rdy_q    <= rdy_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign bus.RDY_OUT  = rdy_q;
    assign bus.DVALID   = dvalid_q;
    assign bus.DOUT     = frame_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_CODE = code_q;
endmodule

// File: tb/tb_sbase_state4_resp.sv
// Directed-vector bench for sbase_state4_resp (timeout scenario only when
// SBASE_RESP_TIMEOUT_EN is defined).
module tb_sbase_state4_resp;
    logic CLK;
    logic R;

    int n_cmp = 0;
    int n_err = 0;

    sbase_state4_resp_if #(.W(8)) bus ();

`ifdef SBASE_RESP_TIMEOUT_EN
    sbase_state4_resp #(.W(8), .TMO_CYC(4)) dut (.CLK(CLK), .R(R), .bus(bus.slave));
`else
    sbase_state4_resp #(.W(8)) dut (.CLK(CLK), .R(R), .bus(bus.slave));
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lines(input logic [3:0] st, input logic [3:0] po);
        {bus.STATE3, bus.STATE2, bus.STATE1, bus.STATE0}         = st;
        {bus.POUT_ONE3, bus.POUT_ONE2, bus.POUT_ONE1, bus.POUT_ONE0} = po;
    endtask

    // One cycle with the given raw lines and data, then lines return to idle.
    task automatic drive(input logic [3:0] st, input logic [3:0] po, input logic [7:0] d);
        set_lines(st, po);
        bus.DIN = d;
        tick();
        set_lines(4'b0000, 4'b0000);
    endtask

    task automatic strobe(input int k, input logic [7:0] d);
        logic [3:0] m;
        m = 4'b0001 << k;
        drive(m, m, d);
    endtask

    task automatic frame(input logic [7:0] d0, d1, d2, d3);
        strobe(0, d0);
        strobe(1, d1);
        strobe(2, d2);
        strobe(3, d3);
    endtask

    task automatic ack();
        bus.DACK = 1'b1;
        tick();
        bus.DACK = 1'b0;
    endtask

    task automatic clr();
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
    endtask

    initial begin
        R           = 1'b1;
        bus.DIN     = '0;
        bus.DACK    = 1'b0;
        bus.ERR_CLR = 1'b0;
        set_lines(4'b0000, 4'b0000);

        // Reset state
        #3;
        check("rst_rdy",    bus.RDY_OUT,  0);
        check("rst_dvalid", bus.DVALID,   0);
        check("rst_dout",   bus.DOUT,     0);
        check("rst_err",    bus.ERR,      0);
        check("rst_code",   bus.ERR_CODE, 0);
        #9 R = 1'b0;
        tick();
        check("rdy_after_rst", bus.RDY_OUT, 1);

        // Normal frame
        strobe(0, 8'h11);
        strobe(1, 8'h22);
        strobe(2, 8'h33);
        check("mid_frame_dvalid", bus.DVALID,  0);
        check("mid_frame_rdy",    bus.RDY_OUT, 1);
        strobe(3, 8'h44);
        check("norm_dvalid", bus.DVALID,  1);
        check("norm_rdy",    bus.RDY_OUT, 0);
        check("norm_dout",   bus.DOUT,    32'h44332211);
        tick();
        check("norm_hold_dvalid", bus.DVALID, 1);
        check("norm_hold_dout",   bus.DOUT,   32'h44332211);
        ack();
        check("ack_dvalid", bus.DVALID,  0);
        check("ack_rdy",    bus.RDY_OUT, 1);
        check("ack_noerr",  bus.ERR,     0);

        // DACK with no frame is ignored
        ack();
        check("idle_ack_dvalid", bus.DVALID,  0);
        check("idle_ack_rdy",    bus.RDY_OUT, 1);

        // Out-of-order then a clean frame
        strobe(0, 8'h01);
        strobe(2, 8'h02);
        check("ooo_err",    bus.ERR,      1);
        check("ooo_code",   bus.ERR_CODE, 1);
        check("ooo_dvalid", bus.DVALID,   0);
        frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        check("ooo_recover_dvalid", bus.DVALID, 1);
        check("ooo_recover_dout",   bus.DOUT,   32'hA3A2A1A0);
        check("ooo_code_sticky",    bus.ERR_CODE, 1);
        ack();
        clr();
        check("clr_err",  bus.ERR,      0);
        check("clr_code", bus.ERR_CODE, 0);

        // Mismatch: two strobes together, then a strobe without its state line
        drive(4'b0110, 4'b0110, 8'h55);
        check("mm_multi_err",  bus.ERR,      1);
        check("mm_multi_code", bus.ERR_CODE, 2);
        drive(4'b0000, 4'b0001, 8'h66);
        check("mm_first_kept", bus.ERR_CODE, 2);
        check("mm_dvalid",     bus.DVALID,   0);
        check("mm_rdy",        bus.RDY_OUT,  1);
        clr();
        check("mm_clr_err",  bus.ERR,      0);
        check("mm_clr_code", bus.ERR_CODE, 0);

        // New error in the same cycle as ERR_CLR wins with its own code
        drive(4'b0110, 4'b0110, 8'h00);
        bus.ERR_CLR = 1'b1;
        strobe(1, 8'h77);
        bus.ERR_CLR = 1'b0;
        check("clr_race_err",  bus.ERR,      1);
        check("clr_race_code", bus.ERR_CODE, 1);
        clr();

        // State lines alone do nothing
        drive(4'b1111, 4'b0000, 8'h99);
        check("state_only_err",    bus.ERR,     0);
        check("state_only_dvalid", bus.DVALID,  0);

        // Overrun while holding a frame
        frame(8'h10, 8'h11, 8'h12, 8'h13);
        strobe(0, 8'hFF);
        check("ovr_err",    bus.ERR,      1);
        check("ovr_code",   bus.ERR_CODE, 3);
        check("ovr_dvalid", bus.DVALID,   1);
        check("ovr_rdy",    bus.RDY_OUT,  0);
        check("ovr_dout",   bus.DOUT,     32'h13121110);
        clr();
        // Mismatch outranks overrun in HOLD
        drive(4'b0011, 4'b0011, 8'hEE);
        check("prio_code", bus.ERR_CODE, 2);
        check("prio_dout", bus.DOUT,     32'h13121110);
        ack();
        clr();

        // Asynchronous reset mid-frame
        strobe(0, 8'hC0);
        strobe(1, 8'hC1);
        #3 R = 1'b1;
        #1;
        check("amid_rst_dout",   bus.DOUT,    0);
        check("amid_rst_rdy",    bus.RDY_OUT, 0);
        check("amid_rst_dvalid", bus.DVALID,  0);
        #2 R = 1'b0;
        tick();
        check("post_rst_rdy", bus.RDY_OUT, 1);
        frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        check("post_rst_dvalid", bus.DVALID, 1);
        check("post_rst_dout",   bus.DOUT,   32'hB3B2B1B0);
        ack();

`ifdef SBASE_RESP_TIMEOUT_EN
        // Timeout after TMO_CYC idle cycles in COLLECT
        strobe(0, 8'hD0);
        repeat (4) tick();
        check("tmo_not_yet", bus.ERR, 0);
        tick();
        check("tmo_err",    bus.ERR,      1);
        check("tmo_code",   bus.ERR_CODE, 4);
        check("tmo_rdy",    bus.RDY_OUT,  1);
        check("tmo_dvalid", bus.DVALID,   0);
        clr();
        frame(8'hE0, 8'hE1, 8'hE2, 8'hE3);
        check("tmo_recover_dout", bus.DOUT, 32'hE3E2E1E0);
        ack();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
